stopwatch_controller: RTL and testbench

//  Run/pause/clear sequencer for the stopwatch digit-counter chain.
//  - Divides clk down to a timebase tick.
//  - Drives a ripple-carry enable chain into NUM_DIGITS digit counters and selects count direction.
//  - Stops a countdown at zero instead of wrapping.
//  - Sits between the debounced button pulses and the counter chain; display mux reads display_hold.

---
 rtl/stopwatch_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 29 ++
 rtl/stopwatch_controller.sv | 116 +++++++++++
 tb/tb_stopwatch_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared state encoding and default timing constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_EXP   = 2'd3
    } state_t;

    localparam int DEFAULT_CLK_HZ  = 100_000_000;
    localparam int DEFAULT_TICK_HZ = 100;

    function automatic int prescale_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a registered one-cycle tick every DIV cycles while run is high.
module tick_prescaler #(
    parameter int DIV        = 1_000_000,
    parameter int PRESCALE_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST     = PRESCALE_W'(DIV - 1);
    localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(DIV - 2);

    logic [PRESCALE_W-1:0] count;

    // tick is registered one count early so it is high exactly while count == LAST;
    // dropping run discards any partial period. DIV must be at least 2.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= (count == LAST) ? '0 : count + PRESCALE_W'(1);
            tick  <= (count == PRE_LAST);
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Run/pause/clear sequencer: divides the clock to a timebase, drives the digit
// enable carry chain, and stops a countdown at zero.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int TICK_HZ    = DEFAULT_TICK_HZ,
    parameter int NUM_DIGITS = 6,
    parameter int PRESCALE_W = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_start_stop,
    input  logic                  btn_clear,
    input  logic                  btn_lap,
    input  logic                  mode_down,
    input  logic [NUM_DIGITS-1:0] digit_threshold,
    output logic [NUM_DIGITS-1:0] digit_enable,
    output logic                  up_down,
    output logic                  counter_clear,
    output logic                  display_hold,
    output logic                  running,
    output logic                  expired,
    output logic                  tick
);

    localparam int DIV = prescale_div(CLK_HZ, TICK_HZ);

    state_t state;
    logic   clr_q;
    logic   zero_all;
    logic   stop_now;
    logic   run_en;
    logic   carry;

    assign zero_all      = ~up_down & (&digit_threshold);
    assign stop_now      = zero_all & tick;
    assign counter_clear = rst | clr_q;
    assign running       = (state == ST_RUN);
    assign expired       = (state == ST_EXP);

    // The prescaler stops in the same cycle RUNNING is left, so it never ticks outside RUNNING.
    assign run_en = (state == ST_RUN) & ~btn_start_stop & ~stop_now;

    tick_prescaler #(
        .DIV        (DIV),
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run_en),
        .tick (tick)
    );

    // Ripple carry: digit i advances only when every lower digit is at its threshold.
    always_comb begin
        carry        = tick & ~stop_now;
        digit_enable = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_enable[i] = carry;
            carry           = carry & digit_threshold[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            up_down      <= 1'b1;
            display_hold <= 1'b0;
            clr_q        <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    up_down <= ~mode_down;
                    // up_down equal to mode_down means the direction is about to flip; re-preset.
                    if (btn_clear || (up_down == mode_down)) begin
                        clr_q <= 1'b1;
                    end
                    if (!btn_clear && btn_start_stop) begin
                        state <= zero_all ? ST_EXP : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop_now) begin
                        state <= ST_EXP;
                    end else if (btn_start_stop) begin
                        state <= ST_PAUSE;
                    end else if (btn_lap) begin
                        display_hold <= ~display_hold;
                    end
                end
                ST_PAUSE: begin
                    if (btn_clear) begin
                        clr_q        <= 1'b1;
                        display_hold <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (btn_start_stop) begin
                        state <= ST_RUN;
                    end else if (btn_lap) begin
                        display_hold <= 1'b0;
                    end
                end
                ST_EXP: begin
                    if (btn_clear || btn_start_stop) begin
                        clr_q        <= 1'b1;
                        display_hold <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed self-checking bench for stopwatch_controller with DIV = 10 and two digits.
module tb_stopwatch_controller;

    logic       clk;
    logic       rst;
    logic       btn_start_stop;
    logic       btn_clear;
    logic       btn_lap;
    logic       mode_down;
    logic [1:0] digit_threshold;
    logic [1:0] digit_enable;
    logic       up_down;
    logic       counter_clear;
    logic       display_hold;
    logic       running;
    logic       expired;
    logic       tick;

    int errors = 0;
    int checks = 0;

    stopwatch_controller #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .NUM_DIGITS (2),
        .PRESCALE_W (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_start_stop  (btn_start_stop),
        .btn_clear       (btn_clear),
        .btn_lap         (btn_lap),
        .mode_down       (mode_down),
        .digit_threshold (digit_threshold),
        .digit_enable    (digit_enable),
        .up_down         (up_down),
        .counter_clear   (counter_clear),
        .display_hold    (display_hold),
        .running         (running),
        .expired         (expired),
        .tick            (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tickClk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic ss, input logic clr, input logic lap);
        btn_start_stop = ss;
        btn_clear      = clr;
        btn_lap        = lap;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        mode_down       = 1'b0;
        digit_threshold = 2'b00;
        applyStimulus(0, 0, 0);

        // Reset held for two edges; counters see clear throughout.
        tickClk(1);
        checkOutput("rst_clear_0", 8'(counter_clear), 8'd1);
        tickClk(1);
        checkOutput("rst_clear_1", 8'(counter_clear), 8'd1);
        checkOutput("rst_running", 8'(running), 8'd0);
        rst = 1'b0;
        tickClk(1);
        checkOutput("idle_running", 8'(running), 8'd0);
        checkOutput("idle_expired", 8'(expired), 8'd0);
        checkOutput("idle_up_down", 8'(up_down), 8'd1);
        checkOutput("idle_enable", 8'(digit_enable), 8'd0);
        checkOutput("idle_tick", 8'(tick), 8'd0);
        checkOutput("idle_clear", 8'(counter_clear), 8'd0);
        checkOutput("idle_hold", 8'(display_hold), 8'd0);

        applyStimulus(0, 1, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("idle_clr_pulse", 8'(counter_clear), 8'd1);
        checkOutput("idle_clr_state", 8'(running), 8'd0);
        tickClk(1);
        checkOutput("idle_clr_end", 8'(counter_clear), 8'd0);

        // Count up: start pulse in cycle 0, ticks in cycles 10 and 20.
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("run_c1", 8'(running), 8'd1);
        checkOutput("run_c1_tick", 8'(tick), 8'd0);
        tickClk(8);
        checkOutput("run_c9_tick", 8'(tick), 8'd0);
        tickClk(1);
        checkOutput("run_c10_tick", 8'(tick), 8'd1);
        checkOutput("run_c10_en00", 8'(digit_enable), 8'b01);
        digit_threshold = 2'b01;
        #1;
        checkOutput("run_c10_en01", 8'(digit_enable), 8'b11);
        digit_threshold = 2'b00;
        tickClk(1);
        checkOutput("run_c11_tick", 8'(tick), 8'd0);
        checkOutput("run_c11_en", 8'(digit_enable), 8'b00);
        tickClk(9);
        checkOutput("run_c20_tick", 8'(tick), 8'd1);

        // Stop pressed on a tick cycle: that tick still enables digit 0.
        applyStimulus(1, 0, 0);
        #1;
        checkOutput("stop_on_tick_en", 8'(digit_enable), 8'b01);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("pause_running", 8'(running), 8'd0);
        checkOutput("pause_tick", 8'(tick), 8'd0);
        tickClk(3);
        checkOutput("pause_hold_tick", 8'(tick), 8'd0);

        // Resume, pause after 5 cycles, resume again: next tick exactly 10 cycles later.
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("resume1_running", 8'(running), 8'd1);
        tickClk(4);
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("pause2_running", 8'(running), 8'd0);
        tickClk(12);
        checkOutput("pause2_tick", 8'(tick), 8'd0);
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("resume2_running", 8'(running), 8'd1);
        tickClk(8);
        checkOutput("resume2_c9_tick", 8'(tick), 8'd0);
        tickClk(1);
        checkOutput("resume2_c10_tick", 8'(tick), 8'd1);

        applyStimulus(0, 1, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("run_clear_ignored", 8'(counter_clear), 8'd0);
        checkOutput("run_clear_state", 8'(running), 8'd1);

        // Lap toggles the frozen display while running.
        applyStimulus(0, 0, 1);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("lap1_hold", 8'(display_hold), 8'd1);
        applyStimulus(0, 0, 1);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("lap2_hold", 8'(display_hold), 8'd0);
        applyStimulus(0, 0, 1);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("lap3_hold", 8'(display_hold), 8'd1);
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("pause3_running", 8'(running), 8'd0);
        checkOutput("pause3_hold", 8'(display_hold), 8'd1);

        // Clear and start together in PAUSED: clear wins.
        applyStimulus(1, 1, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("pclr_pulse", 8'(counter_clear), 8'd1);
        checkOutput("pclr_running", 8'(running), 8'd0);
        checkOutput("pclr_hold", 8'(display_hold), 8'd0);
        tickClk(1);
        checkOutput("pclr_end", 8'(counter_clear), 8'd0);
        checkOutput("pclr_idle", 8'(running), 8'd0);

        // Countdown: direction flip re-presets once.
        mode_down = 1'b1;
        tickClk(1);
        checkOutput("down_up_down", 8'(up_down), 8'd0);
        checkOutput("down_clr", 8'(counter_clear), 8'd1);
        tickClk(1);
        checkOutput("down_clr_end", 8'(counter_clear), 8'd0);
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("down_running", 8'(running), 8'd1);
        digit_threshold = 2'b11;
        tickClk(8);
        checkOutput("down_c9_running", 8'(running), 8'd1);
        checkOutput("down_c9_en", 8'(digit_enable), 8'b00);
        tickClk(1);
        checkOutput("down_c10_tick", 8'(tick), 8'd1);
        checkOutput("down_c10_en", 8'(digit_enable), 8'b00);
        tickClk(1);
        checkOutput("down_expired", 8'(expired), 8'd1);
        checkOutput("down_exp_running", 8'(running), 8'd0);
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("exp_start_clr", 8'(counter_clear), 8'd1);
        checkOutput("exp_start_idle", 8'(expired), 8'd0);
        checkOutput("exp_start_run", 8'(running), 8'd0);

        // Start in IDLE while already at zero goes straight to EXPIRED.
        tickClk(1);
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("idle_zero_exp", 8'(expired), 8'd1);
        applyStimulus(0, 1, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("exp_clear_idle", 8'(expired), 8'd0);
        checkOutput("exp_clear_clr", 8'(counter_clear), 8'd1);
        digit_threshold = 2'b00;
        mode_down       = 1'b0;
        tickClk(1);
        checkOutput("up_again", 8'(up_down), 8'd1);
        checkOutput("up_again_clr", 8'(counter_clear), 8'd1);
        tickClk(1);
        checkOutput("up_again_clr_end", 8'(counter_clear), 8'd0);

        // Reset at prescale count 7, then a clean restart.
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("rst_run_running", 8'(running), 8'd1);
        tickClk(7);
        rst = 1'b1;
        tickClk(1);
        checkOutput("midrst_running", 8'(running), 8'd0);
        checkOutput("midrst_tick", 8'(tick), 8'd0);
        checkOutput("midrst_en", 8'(digit_enable), 8'b00);
        checkOutput("midrst_clr", 8'(counter_clear), 8'd1);
        rst = 1'b0;
        tickClk(1);
        checkOutput("postrst_tick", 8'(tick), 8'd0);
        checkOutput("postrst_clr", 8'(counter_clear), 8'd0);
        checkOutput("postrst_running", 8'(running), 8'd0);
        applyStimulus(1, 0, 0);
        tickClk(1);
        applyStimulus(0, 0, 0);
        checkOutput("restart_running", 8'(running), 8'd1);
        tickClk(8);
        checkOutput("restart_c9_tick", 8'(tick), 8'd0);
        tickClk(1);
        checkOutput("restart_c10_tick", 8'(tick), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
